// File: rtl/k423_ex_bpu_upd_pkg.sv
// Types and helpers for the EX-stage branch resolution / BPU update block.
`include "k423_defines.svh"

package k423_ex_bpu_upd_pkg;

    localparam int CORE_DATA_W = `K423_CORE_DATA_W;
    localparam int UPD_W       = `UPD_W;

    // Correct next fetch PC for a resolved branch; the add wraps silently.
    function automatic logic [CORE_DATA_W-1:0] redir_target(
        input logic                   tkn,
        input logic [CORE_DATA_W-1:0] src_pc,
        input logic [CORE_DATA_W-1:0] tgt_pc,
        input logic [CORE_DATA_W-1:0] pc_inc
    );
        return tkn ? tgt_pc : (src_pc + pc_inc);
    endfunction

endpackage

// File: rtl/k423_bpu_upd_fifo.sv
// Generic synchronous FIFO: flop array, extra-MSB pointers, no bypass.
module k423_bpu_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; wraps naturally through the extra MSB
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Pointer registers; reset empties the queue
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/k423_defines.svh
// Shared core-wide widths and the BPU update-entry field layout.
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH

`define K423_CORE_DATA_W    32

// Default depth of the EX-to-IF branch update queue
`define BPU_UPD_FIFO_DEPTH  4

// Update entry layout: {tkn, src_pc, tgt_pc}
`define UPD_TGT_BITS        31:0
`define UPD_SRC_BITS        63:32
`define UPD_TKN_BITS        64
`define UPD_W               65

`endif

// File: rtl/k423_ex_bpu_upd.sv
// End-of-EX branch resolution: mispredict redirect, perf counters and a
// queued update stream towards the IF-stage BTB/BHT.
`include "k423_defines.svh"

module k423_ex_bpu_upd
    import k423_ex_bpu_upd_pkg::*;
#(
    parameter int UPD_FIFO_DEPTH = `BPU_UPD_FIFO_DEPTH,
    parameter int PC_INC         = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   res_vld_i,
    output logic                   res_rdy_o,
    input  logic                   res_is_br_i,
    input  logic                   res_tkn_i,
    input  logic [CORE_DATA_W-1:0] res_src_pc_i,
    input  logic [CORE_DATA_W-1:0] res_tgt_pc_i,
    input  logic                   res_prd_tkn_i,
    input  logic [CORE_DATA_W-1:0] res_prd_tgt_pc_i,
    output logic                   upd_vld_o,
    input  logic                   upd_rdy_i,
    output logic                   upd_tkn_o,
    output logic [CORE_DATA_W-1:0] upd_src_pc_o,
    output logic [CORE_DATA_W-1:0] upd_tgt_pc_o,
    output logic                   redir_vld_o,
    output logic [CORE_DATA_W-1:0] redir_pc_o,
    output logic [31:0]            perf_br_cnt_o,
    output logic [31:0]            perf_mis_cnt_o
);
    logic             fifo_full, fifo_empty;
    logic             acc, mis;
    logic [UPD_W-1:0] push_entry, head_entry;

    logic                   redir_vld_q, redir_vld_d;
    logic [CORE_DATA_W-1:0] redir_pc_q, redir_pc_d;
    logic [31:0]            br_cnt_q, br_cnt_d;
    logic [31:0]            mis_cnt_q, mis_cnt_d;

    // Ready depends on queue state only, never on upd_rdy_i
    assign res_rdy_o = ~fifo_full;
    assign acc       = res_vld_i & res_rdy_o & res_is_br_i;
    assign mis       = (res_tkn_i ^ res_prd_tkn_i) |
                       (res_tkn_i & res_prd_tkn_i & (res_tgt_pc_i != res_prd_tgt_pc_i));

    assign push_entry[`UPD_TKN_BITS] = res_tkn_i;
    assign push_entry[`UPD_SRC_BITS] = res_src_pc_i;
    assign push_entry[`UPD_TGT_BITS] = res_tgt_pc_i;

    k423_bpu_upd_fifo #(
        .W     (UPD_W),
        .DEPTH (UPD_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (acc),
        .wdata_i (push_entry),
        .pop_i   (upd_vld_o & upd_rdy_i),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign upd_vld_o    = ~fifo_empty;
    assign upd_tkn_o    = head_entry[`UPD_TKN_BITS];
    assign upd_src_pc_o = head_entry[`UPD_SRC_BITS];
    assign upd_tgt_pc_o = head_entry[`UPD_TGT_BITS];

    // Redirect pulses for one cycle per mispredict; PC holds between pulses
    always_comb begin
        redir_vld_d = acc & mis;
        redir_pc_d  = redir_pc_q;
        if (acc & mis)
            redir_pc_d = redir_target(res_tkn_i, res_src_pc_i, res_tgt_pc_i,
                                      CORE_DATA_W'(PC_INC));
        br_cnt_d  = acc ? br_cnt_q + 32'd1 : br_cnt_q;
        mis_cnt_d = (acc & mis) ? mis_cnt_q + 32'd1 : mis_cnt_q;
    end

    // Redirect and perf counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            br_cnt_q    <= br_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    assign redir_vld_o    = redir_vld_q;
    assign redir_pc_o     = redir_pc_q;
    assign perf_br_cnt_o  = br_cnt_q;
    assign perf_mis_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_k423_ex_bpu_upd.sv
// Self-checking bench for k423_ex_bpu_upd against a queue-based reference model.
module tb_k423_ex_bpu_upd;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_vld, res_rdy, res_is_br, res_tkn, res_prd_tkn;
    logic [31:0] res_src, res_tgt, res_prd_tgt;
    logic        upd_vld, upd_rdy, upd_tkn;
    logic [31:0] upd_src, upd_tgt;
    logic        redir_vld;
    logic [31:0] redir_pc, br_cnt, mis_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    k423_ex_bpu_upd #(.UPD_FIFO_DEPTH(DEPTH), .PC_INC(4)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .res_vld_i        (res_vld),
        .res_rdy_o        (res_rdy),
        .res_is_br_i      (res_is_br),
        .res_tkn_i        (res_tkn),
        .res_src_pc_i     (res_src),
        .res_tgt_pc_i     (res_tgt),
        .res_prd_tkn_i    (res_prd_tkn),
        .res_prd_tgt_pc_i (res_prd_tgt),
        .upd_vld_o        (upd_vld),
        .upd_rdy_i        (upd_rdy),
        .upd_tkn_o        (upd_tkn),
        .upd_src_pc_o     (upd_src),
        .upd_tgt_pc_o     (upd_tgt),
        .redir_vld_o      (redir_vld),
        .redir_pc_o       (redir_pc),
        .perf_br_cnt_o    (br_cnt),
        .perf_mis_cnt_o   (mis_cnt)
    );

    // Reference model: architectural view of queue, counters and redirect
    typedef struct { bit tkn; logic [31:0] src; logic [31:0] tgt; } ent_t;
    ent_t        mq[$];
    ent_t        m_popped;
    logic [31:0] m_br, m_mis, m_rpc;
    bit          m_redir, m_acc, m_pop;

    task automatic drive(input bit v, input bit br, input bit t, input logic [31:0] s,
                         input logic [31:0] g, input bit pt, input logic [31:0] pg);
        res_vld = v; res_is_br = br; res_tkn = t; res_src = s;
        res_tgt = g; res_prd_tkn = pt; res_prd_tgt = pg;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle
    task automatic tick();
        bit mis;
        ent_t e;
        m_acc = 0; m_pop = 0;
        if (!rst_n) begin
            mq.delete();
            m_br = 0; m_mis = 0; m_redir = 0; m_rpc = 0;
        end else begin
            // wrong if the predicted next PC differs from the actual next PC
            mis = (res_tkn != res_prd_tkn) || (res_tkn && res_tgt != res_prd_tgt);
            m_acc = res_vld && res_is_br && (mq.size() < DEPTH);
            m_pop = (mq.size() != 0) && upd_rdy;
            if (m_pop) m_popped = mq.pop_front();
            m_redir = m_acc && mis;
            if (m_acc) begin
                e.tkn = res_tkn; e.src = res_src; e.tgt = res_tgt;
                mq.push_back(e);
                m_br++;
                if (mis) m_mis++;
            end
            if (m_redir) m_rpc = res_tkn ? res_tgt : res_src + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; upd_rdy = 1; idle();
        tick(); tick();
        rst_n = 1;
        tick();
        n_tests++; if (res_rdy !== 1'b1)    begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", res_rdy); end
        n_tests++; if (upd_vld !== 1'b0)    begin n_fail++; $display("FAIL reset_upd_vld got=%b exp=0", upd_vld); end
        n_tests++; if (redir_vld !== 1'b0 || redir_pc !== 32'h0)
            begin n_fail++; $display("FAIL reset_redir got=%b/%h exp=0/0", redir_vld, redir_pc); end
        n_tests++; if (br_cnt !== 32'h0 || mis_cnt !== 32'h0)
            begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_cnt, mis_cnt); end
    endtask

    task automatic test_correct_taken();
        upd_rdy = 1;
        drive(1, 1, 1, 32'h100, 32'h200, 1, 32'h200);
        tick(); idle();
        n_tests++; if (redir_vld !== 1'b0) begin n_fail++; $display("FAIL ct_redir got=%b exp=0", redir_vld); end
        n_tests++; if (upd_vld !== 1'b1 || upd_tkn !== 1'b1 || upd_src !== 32'h100 || upd_tgt !== 32'h200)
            begin n_fail++; $display("FAIL ct_upd got=%b %b %h %h exp=1 1 100 200", upd_vld, upd_tkn, upd_src, upd_tgt); end
        n_tests++; if (br_cnt !== 32'd1 || mis_cnt !== 32'd0)
            begin n_fail++; $display("FAIL ct_cnt got=%0d/%0d exp=1/0", br_cnt, mis_cnt); end
        tick();
        n_tests++; if (upd_vld !== 1'b0) begin n_fail++; $display("FAIL ct_drain got=%b exp=0", upd_vld); end
    endtask

    task automatic test_dir_mispredict();
        upd_rdy = 1;
        drive(1, 1, 0, 32'h80, 32'h1234, 1, 32'h1234);
        tick(); idle();
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 32'h84)
            begin n_fail++; $display("FAIL dir_redir got=%b/%h exp=1/84", redir_vld, redir_pc); end
        n_tests++; if (mis_cnt !== 32'd1) begin n_fail++; $display("FAIL dir_mis_cnt got=%0d exp=1", mis_cnt); end
        tick();
        n_tests++; if (redir_vld !== 1'b0 || redir_pc !== 32'h84)
            begin n_fail++; $display("FAIL dir_pulse got=%b/%h exp=0/84", redir_vld, redir_pc); end
        tick();
    endtask

    // Target mispredict followed immediately by a wrapping not-taken mispredict
    task automatic test_tgt_and_wrap();
        upd_rdy = 1;
        drive(1, 1, 1, 32'h500, 32'h300, 1, 32'h340);
        tick();
        drive(1, 1, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10);
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 32'h300)
            begin n_fail++; $display("FAIL tgt_redir got=%b/%h exp=1/300", redir_vld, redir_pc); end
        tick(); idle();
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 32'h0)
            begin n_fail++; $display("FAIL wrap_redir got=%b/%h exp=1/0", redir_vld, redir_pc); end
        n_tests++; if (mis_cnt !== m_mis) begin n_fail++; $display("FAIL wrap_mis_cnt got=%0d exp=%0d", mis_cnt, m_mis); end
        tick(); tick();
        n_tests++; if (redir_vld !== 1'b0 || upd_vld !== 1'b0)
            begin n_fail++; $display("FAIL wrap_idle got=%b/%b exp=0/0", redir_vld, upd_vld); end
    endtask

    task automatic test_full_stall();
        logic [31:0] srcs [5];
        int k, budget;
        bit acc5;
        upd_rdy = 0;
        for (int i = 0; i < 5; i++) srcs[i] = 32'h1000 + 32'(i) * 32'h10;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i[0], srcs[i], srcs[i] + 32'h400, i[0], srcs[i] + 32'h400);
            tick();
        end
        n_tests++; if (res_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy got=%b exp=0", res_rdy); end
        drive(1, 1, 1, srcs[4], 32'h7000, 1, 32'h7000);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (res_rdy !== 1'b0 || upd_src !== srcs[0] || upd_tgt !== srcs[0] + 32'h400 || br_cnt !== m_br)
                begin n_fail++; $display("FAIL stall_hold got=rdy%b src%h tgt%h br%0d exp=0 %h %h %0d",
                                         res_rdy, upd_src, upd_tgt, br_cnt, srcs[0], srcs[0] + 32'h400, m_br); end
        end
        upd_rdy = 1;
        k = 0; acc5 = 0; budget = 20;
        while ((k < 5 || !acc5) && budget > 0) begin
            n_tests++; if (upd_vld !== 1'b1 || upd_src !== srcs[k])
                begin n_fail++; $display("FAIL drain_order[%0d] got=%b/%h exp=1/%h", k, upd_vld, upd_src, srcs[k]); end
            tick();
            if (m_pop) k++;
            if (m_acc) begin acc5 = 1; idle(); end
            budget--;
        end
        n_tests++; if (budget == 0) begin n_fail++; $display("FAIL drain_timeout got=%0d pops exp=5", k); end
        n_tests++; if (upd_vld !== 1'b0 || res_rdy !== 1'b1)
            begin n_fail++; $display("FAIL drain_end got=%b/%b exp=0/1", upd_vld, res_rdy); end
    endtask

    task automatic test_reset_mid();
        upd_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 32'h2000 + 32'(i), 32'h3000, 0, 32'h0);
            tick();
        end
        idle();
        n_tests++; if (upd_vld !== 1'b1 || redir_vld !== 1'b1)
            begin n_fail++; $display("FAIL mid_pre got=%b/%b exp=1/1", upd_vld, redir_vld); end
        rst_n = 0; tick(); rst_n = 1;
        n_tests++; if (upd_vld !== 1'b0 || res_rdy !== 1'b1 || br_cnt !== 32'h0 || mis_cnt !== 32'h0 || redir_vld !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset got=vld%b rdy%b br%0d mis%0d redir%b exp=0 1 0 0 0",
                                     upd_vld, res_rdy, br_cnt, mis_cnt, redir_vld); end
        upd_rdy = 1; tick();
    endtask

    task automatic test_non_branch();
        upd_rdy = 1;
        drive(1, 0, 1, 32'h40, 32'h999, 0, 32'h0);
        tick(); idle();
        n_tests++; if (upd_vld !== 1'b0 || redir_vld !== 1'b0 || br_cnt !== m_br || mis_cnt !== m_mis)
            begin n_fail++; $display("FAIL non_branch got=vld%b redir%b br%0d mis%0d exp=0 0 %0d %0d",
                                     upd_vld, redir_vld, br_cnt, mis_cnt, m_br, m_mis); end
    endtask

    task automatic test_random();
        logic [31:0] s, g;
        bit t, pt;
        for (int c = 0; c < 400; c++) begin
            s  = $urandom & 32'hFFFF_FFFC;
            g  = $urandom & 32'hFFFF_FFFC;
            t  = 1'($urandom);
            pt = ($urandom_range(0, 3) == 0) ? ~t : t;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), t, s, g, pt,
                  ($urandom_range(0, 3) == 0) ? g + 32'h8 : g);
            upd_rdy = 1'($urandom_range(0, 2) != 0);
            tick();
            n_tests++;
            if (res_rdy !== (mq.size() < DEPTH) || upd_vld !== (mq.size() != 0) ||
                redir_vld !== m_redir || redir_pc !== m_rpc || br_cnt !== m_br || mis_cnt !== m_mis ||
                (mq.size() != 0 && (upd_tkn !== mq[0].tkn || upd_src !== mq[0].src || upd_tgt !== mq[0].tgt))) begin
                n_fail++;
                $display("FAIL rand[%0d] got=rdy%b vld%b rd%b/%h br%0d mis%0d h%h exp=rdy%b vld%b rd%b/%h br%0d mis%0d h%h",
                         c, res_rdy, upd_vld, redir_vld, redir_pc, br_cnt, mis_cnt, upd_src,
                         mq.size() < DEPTH, mq.size() != 0, m_redir, m_rpc, m_br, m_mis,
                         (mq.size() != 0) ? mq[0].src : 32'h0);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_dir_mispredict();
        test_tgt_and_wrap();
        test_full_stall();
        test_reset_mid();
        test_non_branch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/k423_ex_bpu_upd.md
# k423_ex_bpu_upd

Branch-resolution side of the BPU update interface. Sits at the end of EX. It takes resolved branch/jump outcomes, compares them against the prediction carried down the pipe, and raises a one-cycle redirect on misprediction. It also buffers each resolution in a small FIFO and drains it one entry per cycle onto the `upd_*` port of the IF-stage BPU (BTB/BHT).

## Interface
Parameters:
- `UPD_FIFO_DEPTH`, 4: update FIFO entries; power of two, ≥2.
- `PC_INC`, 4: fall-through increment for not-taken redirects.

Ports:
- `clk_i` in 1: core clock.
- `rst_n_i` in 1: reset; one clock, synchronous, active-low.
- `res_vld_i` in 1: resolution valid from EX.
- `res_rdy_o` out 1: block can accept a resolution.
- `res_is_br_i` in 1: instruction is a branch/jump; 0 means pass-through with no action.
- `res_tkn_i` in 1: actual direction.
- `res_src_pc_i` in `CORE_DATA_W`: branch PC.
- `res_tgt_pc_i` in `CORE_DATA_W`: actual target.
- `res_prd_tkn_i` in 1: predicted direction.
- `res_prd_tgt_pc_i` in `CORE_DATA_W`: predicted target.
- `upd_vld_o` out 1: update valid to BPU.
- `upd_rdy_i` in 1: BPU accepts the update this cycle.
- `upd_tkn_o` out 1: update direction.
- `upd_src_pc_o` out `CORE_DATA_W`: update PC.
- `upd_tgt_pc_o` out `CORE_DATA_W`: update target.
- `redir_vld_o` out 1: mispredict redirect pulse to IF.
- `redir_pc_o` out `CORE_DATA_W`: correct fetch PC.
- `perf_br_cnt_o` out 32: resolved branches.
- `perf_mis_cnt_o` out 32: mispredicts.

## Operation
- Accept: `acc = res_vld_i & res_rdy_o & res_is_br_i`. Handshakes with `res_is_br_i=0` are consumed and ignored.
- `res_rdy_o = ~fifo_full`. It is registered-state only and has no combinational path from `upd_rdy_i`. When the FIFO is full, a same-cycle pop does not raise ready.
- Mispredict: `mis = (res_tkn_i ^ res_prd_tkn_i) | (res_tkn_i & res_prd_tkn_i & (res_tgt_pc_i != res_prd_tgt_pc_i))`.
- Redirect PC: `res_tkn_i ? res_tgt_pc_i : res_src_pc_i + PC_INC`. The add is modulo 2^`CORE_DATA_W` and wraps silently.
- On `acc`:
  - Push entry {tkn, src_pc, tgt_pc} into the FIFO. Not-taken entries are pushed too; the BTB ignores them and the BHT consumes them.
  - `perf_br_cnt` increments by 1.
  - If `mis`, `perf_mis_cnt` also increments by 1.
  - Counters wrap at 2^32.
- FIFO head drives `upd_*_o`. `upd_vld_o = ~fifo_empty`. Pop on `upd_vld_o & upd_rdy_i`.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, ordering preserved.
- Push into an empty FIFO is visible on `upd_vld_o` the next cycle. There is no bypass.
- Payload stability: while `upd_vld_o & ~upd_rdy_i`, `upd_*_o` hold steady.
- Pointers are `log2(UPD_FIFO_DEPTH)+1` bits. Full/empty is decided by MSB compare, and pointers wrap naturally.

## Timing
- Reset (`rst_n_i=0` at a clock edge) clears the following to 0:
  - FIFO pointers, so `upd_vld_o=0`, `res_rdy_o=1` after reset.
  - `redir_vld_o=0`, `redir_pc_o=0`.
  - Both perf counters.
- Reset mid-operation discards all queued updates, with no partial drain.
- Redirect latency is 1: `redir_vld_o`/`redir_pc_o` are registered from the `acc & mis` cycle and held for exactly one cycle.
  - Back-to-back mispredicts give back-to-back pulses, each with its own PC.
  - `redir_pc_o` holds its last value when `redir_vld_o=0`.
- Update latency is ≥1 cycle from accept to `upd_vld_o`, plus queueing behind earlier entries.
- Throughput: 1 accept/cycle while not full; 1 drain/cycle while `upd_rdy_i=1`.
- Counters are registered and visible the cycle after `acc`.
- Redirect generation is independent of FIFO drain; a mispredict still redirects even if its update is queued behind others.

## Structure
- In `k423_defines.svh`: `BPU_UPD_FIFO_DEPTH` default, and the update-entry field ranges `UPD_TKN_BITS`, `UPD_SRC_BITS`, `UPD_TGT_BITS`, `UPD_W`, in the same style as the `BTB_*_BITS` macros.
- One sub-module, `k423_bpu_upd_fifo`: a generic synchronous FIFO (width, depth parameters; push/pop/full/empty; flop array, no bypass).
- Top-level holds the compare logic, redirect register and counters.

## Test plan
- Reset, then idle: `res_rdy_o=1`, `upd_vld_o=0`, `redir_vld_o=0`, counters 0.
- Correct taken branch, src=0x100, tgt=0x200, prd_tkn=1, prd_tgt=0x200:
  - no redirect;
  - the next cycle gives `upd_vld_o=1`, tkn=1, src=0x100, tgt=0x200;
  - br_cnt=1, mis_cnt=0.
- Direction mispredict, src=0x80, tkn=0, prd_tkn=1: next cycle `redir_vld_o=1`, `redir_pc_o=0x84` for one cycle; mis_cnt=1.
- Target mispredict, tkn=1, tgt=0x300, prd_tgt=0x340: redirect to 0x300. Wrap case: src=0xFFFF_FFFC not-taken gives redirect 0x0.
- `upd_rdy_i=0`, push 4 branches:
  - `res_rdy_o` drops after the 4th, and a 5th `res_vld_i` stalls;
  - `upd_*` stay stable;
  - raise `upd_rdy_i`: drain order is 0,1,2,3, one per cycle, then the stalled 5th is accepted.
- Assert reset with 3 queued entries: the next cycle gives `upd_vld_o=0`, `res_rdy_o=1`, counters 0. Also check that a `res_is_br_i=0` handshake changes nothing.
